// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - sound codes, note format, FSM states and constant tables for the sequencer
package audio_pkg;

    localparam logic [3:0] SND_NONE    = 4'd0;
    localparam logic [3:0] SND_THEME   = 4'd1;
    localparam logic [3:0] SND_BONUS   = 4'd2;
    localparam logic [3:0] SND_COLLIDE = 4'd4;
    localparam logic [3:0] SND_WIN     = 4'd8;
    localparam logic [3:0] SND_LOSE    = 4'd9;

    localparam int ROM_DEPTH = 64;

    typedef struct packed {
        logic [3:0] tone;
        logic [3:0] dur;
        logic       last;
    } note_t;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_LATCH, ST_PLAY, ST_NEXT} seq_state_t;

    // Half-period counts for C5..B5 at 50 MHz; 0 and 13..15 are rests.
    localparam logic [15:0] TONE_DIV [16] = '{
        16'd0,     16'd47778, 16'd45097, 16'd42566, 16'd40177, 16'd37922,
        16'd35793, 16'd33784, 16'd31888, 16'd30098, 16'd28409, 16'd26815,
        16'd25310, 16'd0,     16'd0,     16'd0
    };

    localparam logic [7:0] START_ADDR [16] = '{
        1: 8'd0, 2: 8'd8, 4: 8'd16, 8: 8'd24, 9: 8'd32, default: 8'd0
    };

    localparam note_t NOTE_ROM_INIT [ROM_DEPTH] = '{
        0:  {4'd5,  4'd2, 1'b0}, 1:  {4'd0,  4'd1, 1'b0},
        2:  {4'd8,  4'd2, 1'b0}, 3:  {4'd3,  4'd1, 1'b1},
        8:  {4'd10, 4'd1, 1'b0}, 9:  {4'd12, 4'd1, 1'b1},
        16: {4'd2,  4'd1, 1'b0}, 17: {4'd1,  4'd1, 1'b0}, 18: {4'd1, 4'd3, 1'b1},
        24: {4'd5,  4'd0, 1'b0}, 25: {4'd7,  4'd0, 1'b0},
        26: {4'd9,  4'd0, 1'b0}, 27: {4'd12, 4'd2, 1'b1},
        32: {4'd6,  4'd1, 1'b0}, 33: {4'd4,  4'd1, 1'b0},
        34: {4'd14, 4'd0, 1'b0}, 35: {4'd2,  4'd3, 1'b1},
        default: 9'd0
    };

    function automatic logic is_sound_code(input logic [3:0] code);
        return code inside {SND_THEME, SND_BONUS, SND_COLLIDE, SND_WIN, SND_LOSE};
    endfunction

    function automatic logic is_audible(input logic [3:0] tone);
        return (tone >= 4'd1) && (tone <= 4'd12);
    endfunction

endpackage

// File: rtl/note_rom.sv
// rtl/note_rom.sv - synchronous melody ROM with one-cycle read latency
module note_rom
    import audio_pkg::*;
#(
    parameter int ROM_AW = 6
) (
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [8:0]        data
);

    always_ff @(posedge clk) begin
        data <= NOTE_ROM_INIT[addr];
    end

endmodule

// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - plays per-code melodies from the note ROM, timed in video frames
module sound_sequencer
    import audio_pkg::*;
#(
    parameter int         DIV_W     = 16,
    parameter int         ROM_AW    = 6,
    parameter logic [3:0] LOOP_CODE = 4'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [3:0]       sound_sel,
    output logic [DIV_W-1:0] tone_div,
    output logic             tone_en,
    output logic [3:0]       active_code,
    output logic             busy,
    output logic             seq_done
);

    seq_state_t        state;
    logic [ROM_AW-1:0] addr;
    logic [3:0]        dur_cnt;
    logic              last_q;
    note_t             rom_q;
    logic [3:0]        sel_eff;
    logic              start_req;
    logic              theme_stop;

    note_rom #(.ROM_AW(ROM_AW)) u_rom (
        .clk  (clk),
        .addr (addr),
        .data (rom_q)
    );

    assign sel_eff    = is_sound_code(sound_sel) ? sound_sel : SND_NONE;
    assign start_req  = (sel_eff != SND_NONE) && ((state == ST_IDLE) || (sel_eff > active_code));
    // Only the looping theme depends on the request staying asserted.
    assign theme_stop = (state != ST_IDLE) && (active_code == LOOP_CODE) && (sel_eff == SND_NONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            addr        <= '0;
            dur_cnt     <= '0;
            last_q      <= 1'b0;
            tone_div    <= '0;
            tone_en     <= 1'b0;
            active_code <= SND_NONE;
            busy        <= 1'b0;
            seq_done    <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            if (start_req) begin
                state       <= ST_LOAD;
                active_code <= sel_eff;
                addr        <= ROM_AW'(START_ADDR[sel_eff]);
                tone_en     <= 1'b0;
                tone_div    <= '0;
                busy        <= 1'b1;
            end else if (theme_stop) begin
                state       <= ST_IDLE;
                active_code <= SND_NONE;
                tone_en     <= 1'b0;
                tone_div    <= '0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_LOAD: state <= ST_LATCH;
                    ST_LATCH: begin
                        dur_cnt  <= rom_q.dur;
                        last_q   <= rom_q.last;
                        tone_div <= DIV_W'(TONE_DIV[rom_q.tone]);
                        tone_en  <= is_audible(rom_q.tone);
                        state    <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (frame_start) begin
                            if (dur_cnt != 4'd0) dur_cnt <= dur_cnt - 4'd1;
                            else                 state   <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        tone_en <= 1'b0;
                        if (!last_q) begin
                            addr  <= addr + ROM_AW'(1);
                            state <= ST_LOAD;
                        end else if (active_code == LOOP_CODE) begin
                            addr  <= ROM_AW'(START_ADDR[active_code]);
                            state <= ST_LOAD;
                        end else begin
                            seq_done    <= 1'b1;
                            active_code <= SND_NONE;
                            tone_div    <= '0;
                            busy        <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - randomized self-checking bench for sound_sequencer
module tb_sound_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [3:0]  sound_sel = 4'd0;
    logic [15:0] tone_div;
    logic        tone_en;
    logic [3:0]  active_code;
    logic        busy;
    logic        seq_done;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    int fs_cnt = 0;

    // Reference model: melodies as note lists, playback as cycle and frame countdowns.
    int   mel_len  [16];
    int   mel_tone [16][4];
    int   mel_dur  [16][4];
    int   m_code = 0, m_idx = 0, m_wait = 0, m_frames = 0, m_tone = 0;
    logic m_en = 1'b0, m_done = 1'b0;

    always #5 clk = ~clk;

    sound_sequencer #(.DIV_W(16), .ROM_AW(6), .LOOP_CODE(4'd1)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .sound_sel   (sound_sel),
        .tone_div    (tone_div),
        .tone_en     (tone_en),
        .active_code (active_code),
        .busy        (busy),
        .seq_done    (seq_done)
    );

    task automatic set_mel(input int code, input int n, input int t0, input int d0, input int t1,
                           input int d1, input int t2, input int d2, input int t3, input int d3);
        mel_len[code] = n;
        mel_tone[code][0] = t0; mel_dur[code][0] = d0;
        mel_tone[code][1] = t1; mel_dur[code][1] = d1;
        mel_tone[code][2] = t2; mel_dur[code][2] = d2;
        mel_tone[code][3] = t3; mel_dur[code][3] = d3;
    endtask

    function automatic logic valid_code(input logic [3:0] s);
        return s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8 || s == 4'd9;
    endfunction

    function automatic real div_ref(input int tone);
        if (tone < 1 || tone > 12) return 0.0;
        return 25.0e6 / (523.2511 * $pow(2.0, real'(tone - 1) / 12.0));
    endfunction

    function automatic real div_err();
        real d;
        d = real'(tone_div) - div_ref(m_tone);
        return (d < 0.0) ? -d : d;
    endfunction

    function automatic logic [6:0] exp_vec();
        return {m_en, 4'(m_code), m_code != 0, m_done};
    endfunction

    function automatic logic [6:0] got_vec();
        return {tone_en, active_code, busy, seq_done};
    endfunction

    function automatic logic gen_fs();
        if (fs_cnt == 0) begin
            fs_cnt = $urandom_range(2, 6);
            return 1'b1;
        end
        fs_cnt--;
        return 1'b0;
    endfunction

    task automatic model_step(input logic [3:0] s, input logic r, input logic fs);
        int se;
        se = valid_code(s) ? int'(s) : 0;
        m_done = 1'b0;
        if (r) begin
            m_code = 0; m_idx = 0; m_wait = 0; m_frames = 0; m_en = 1'b0; m_tone = 0;
        end else if (se != 0 && se > m_code) begin
            m_code = se; m_idx = 0; m_wait = 2; m_frames = 0; m_en = 1'b0; m_tone = 0;
        end else if (m_code == 1 && se == 0) begin
            m_code = 0; m_wait = 0; m_frames = 0; m_en = 1'b0; m_tone = 0;
        end else if (m_code != 0) begin
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_tone   = mel_tone[m_code][m_idx];
                    m_en     = (m_tone >= 1 && m_tone <= 12);
                    m_frames = mel_dur[m_code][m_idx] + 1;
                end
            end else if (m_frames > 0) begin
                if (fs) m_frames--;
            end else begin
                m_en = 1'b0;
                if (m_idx + 1 < mel_len[m_code]) begin
                    m_idx++; m_wait = 2;
                end else if (m_code == 1) begin
                    m_idx = 0; m_wait = 2;
                end else begin
                    m_done = 1'b1; m_code = 0; m_tone = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic [3:0] s, input logic r, input logic fs);
        sound_sel = s; reset = r; frame_start = fs;
        @(posedge clk);
        model_step(s, r, fs);
        cyc_n++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(4'd4, 1'b1, 1'b1);
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75) begin
                errors++; $display("FAIL reset_state cyc=%0d got=%b div=%0d exp=%b", cyc_n, got_vec(), tone_div, exp_vec());
            end
        end
    endtask

    task automatic test_idle();
        int frames = 0;
        logic fs;
        while (frames < 100) begin
            fs = gen_fs();
            frames += int'(fs);
            cyc(4'd0, 1'b0, fs);
            checks++;
            if (got_vec() !== exp_vec() || tone_div !== 16'd0) begin
                errors++; $display("FAIL idle cyc=%0d got=%b div=%0d exp=%b div=0", cyc_n, got_vec(), tone_div, exp_vec());
            end
        end
    endtask

    task automatic test_invalid_codes();
        logic [3:0] bad [10] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        for (int i = 0; i < 40; i++) begin
            cyc(bad[$urandom_range(0, 9)], 1'b0, gen_fs());
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75) begin
                errors++; $display("FAIL invalid_code cyc=%0d got=%b div=%0d exp=%b", cyc_n, got_vec(), tone_div, exp_vec());
            end
        end
    endtask

    task automatic test_collision();
        int acc, rise = -1, dones = 0, n = 0;
        cyc(4'd4, 1'b0, gen_fs());
        acc = cyc_n;
        do begin
            if (n > 0) cyc(4'd0, 1'b0, gen_fs());
            n++;
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75) begin
                errors++; $display("FAIL collision cyc=%0d got=%b div=%0d exp=%b exp_div=%0.1f", cyc_n, got_vec(), tone_div, exp_vec(), div_ref(m_tone));
            end
            if (tone_en === 1'b1 && rise < 0) rise = cyc_n;
            if (seq_done === 1'b1) dones++;
        end while (busy === 1'b1 && n < 400);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL collision_timeout busy=%b required 0", busy); end
        checks++;
        if (rise - acc !== 2) begin errors++; $display("FAIL collision_latency got=%0d required 2", rise - acc); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL collision_done_pulses got=%0d required 1", dones); end
        checks++;
        if (active_code !== 4'd0) begin errors++; $display("FAIL collision_code_after got=%0d required 0", active_code); end
    endtask

    task automatic test_preempt();
        int n = 0;
        while (tone_en !== 1'b1 && n < 50) begin
            cyc(4'd1, 1'b0, gen_fs()); n++;
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75) begin
                errors++; $display("FAIL preempt_theme cyc=%0d got=%b div=%0d exp=%b", cyc_n, got_vec(), tone_div, exp_vec());
            end
        end
        checks++;
        if (tone_en !== 1'b1) begin errors++; $display("FAIL preempt_theme_start tone_en=%b required 1", tone_en); end
        repeat ($urandom_range(1, 3)) cyc(4'd1, 1'b0, gen_fs());
        cyc(4'd4, 1'b0, gen_fs());
        checks++;
        if (active_code !== 4'd4 || tone_en !== 1'b0) begin
            errors++; $display("FAIL preempt_code got code=%0d en=%b required code=4 en=0", active_code, tone_en);
        end
        n = 0;
        while ((busy === 1'b1 || n < 20) && n < 400) begin
            cyc(4'd0, 1'b0, gen_fs()); n++;
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75) begin
                errors++; $display("FAIL preempt_run cyc=%0d got=%b div=%0d exp=%b", cyc_n, got_vec(), tone_div, exp_vec());
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL preempt_timeout busy=%b required 0", busy); end
    endtask

    task automatic test_lower_priority();
        int n = 0;
        cyc(4'd4, 1'b0, gen_fs());
        for (int i = 0; i < 12; i++) begin
            cyc(4'd2, 1'b0, gen_fs());
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75 || active_code !== 4'd4) begin
                errors++; $display("FAIL lower_ignored cyc=%0d got=%b div=%0d exp=%b code must stay 4", cyc_n, got_vec(), tone_div, exp_vec());
            end
        end
        while (busy === 1'b1 && n < 400) begin
            cyc(4'd0, 1'b0, gen_fs()); n++;
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75) begin
                errors++; $display("FAIL lower_run cyc=%0d got=%b div=%0d exp=%b", cyc_n, got_vec(), tone_div, exp_vec());
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL lower_timeout busy=%b required 0", busy); end
    endtask

    task automatic test_theme_loop();
        int dones = 0, idles = 0, firsts = 0;
        logic prev_en = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(4'd1, 1'b0, gen_fs());
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75) begin
                errors++; $display("FAIL theme_loop cyc=%0d got=%b div=%0d exp=%b", cyc_n, got_vec(), tone_div, exp_vec());
            end
            if (seq_done === 1'b1) dones++;
            if (busy !== 1'b1) idles++;
            if (tone_en === 1'b1 && !prev_en && (real'(tone_div) - div_ref(5)) ** 2 < 1.0) firsts++;
            prev_en = tone_en;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL theme_no_done got=%0d required 0", dones); end
        checks++;
        if (idles !== 0) begin errors++; $display("FAIL theme_busy idle_cycles=%0d required 0", idles); end
        checks++;
        if (firsts < 2) begin errors++; $display("FAIL theme_loops first_note_starts=%0d required >=2", firsts); end
        cyc(4'd0, 1'b0, gen_fs());
        checks++;
        if (got_vec() !== exp_vec() || busy !== 1'b0 || tone_en !== 1'b0 || tone_div !== 16'd0) begin
            errors++; $display("FAIL theme_stop got=%b div=%0d required all 0", got_vec(), tone_div);
        end
    endtask

    task automatic test_reset_mid_play();
        int n = 0;
        while (tone_en !== 1'b1 && n < 50) begin
            cyc(4'd1, 1'b0, gen_fs()); n++;
        end
        cyc(4'd1, 1'b1, 1'b1);
        checks++;
        if (got_vec() !== 7'd0 || tone_div !== 16'd0 || got_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_mid_play got=%b div=%0d required all 0", got_vec(), tone_div);
        end
        cyc(4'd0, 1'b0, gen_fs());
        checks++;
        if (got_vec() !== exp_vec() || div_err() > 0.75) begin
            errors++; $display("FAIL reset_after got=%b div=%0d exp=%b", got_vec(), tone_div, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        cyc(4'd8, 1'b0, gen_fs());
        while (seq_done !== 1'b1 && n < 400) begin
            cyc(4'd0, 1'b0, gen_fs()); n++;
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75) begin
                errors++; $display("FAIL b2b_win cyc=%0d got=%b div=%0d exp=%b", cyc_n, got_vec(), tone_div, exp_vec());
            end
        end
        cyc(4'd9, 1'b0, gen_fs());
        checks++;
        if (active_code !== 4'd9 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_lose_start got code=%0d busy=%b required code=9 busy=1", active_code, busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            cyc(4'd0, 1'b0, gen_fs()); n++;
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75) begin
                errors++; $display("FAIL b2b_lose cyc=%0d got=%b div=%0d exp=%b", cyc_n, got_vec(), tone_div, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] pool [12] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd7, 4'd15};
        logic [3:0] s = 4'd0;
        int hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                s = pool[$urandom_range(0, 11)];
                hold = $urandom_range(1, 40);
            end
            hold--;
            cyc(s, $urandom_range(0, 499) == 0, gen_fs());
            checks++;
            if (got_vec() !== exp_vec() || div_err() > 0.75) begin
                errors++; $display("FAIL random cyc=%0d sel=%0d got=%b div=%0d exp=%b exp_div=%0.1f", cyc_n, s, got_vec(), tone_div, exp_vec(), div_ref(m_tone));
            end
        end
    endtask

    initial begin
        set_mel(1, 4, 5, 2, 0, 1, 8, 2, 3, 1);
        set_mel(2, 2, 10, 1, 12, 1, 0, 0, 0, 0);
        set_mel(4, 3, 2, 1, 1, 1, 1, 3, 0, 0);
        set_mel(8, 4, 5, 0, 7, 0, 9, 0, 12, 2);
        set_mel(9, 4, 6, 1, 4, 1, 14, 0, 2, 3);
        test_reset();
        test_idle();
        test_invalid_codes();
        test_collision();
        test_preempt();
        test_lower_priority();
        test_theme_loop();
        test_reset_mid_play();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Consumes the 4-bit sound-request code from the game-event audio mux and plays the matching short melody, one note at a time, from an internal note ROM.
- Note durations are counted in video frames, using the frame_start tick.
- Drives a tone divider and enable to the downstream square-wave tone generator.
- Sits between the event mux and the tone generator in the audio path.

Parameters:
- DIV_W, 16, width of the tone divider output.
- ROM_AW, 6, note ROM address width (64 entries).
- LOOP_CODE, 4'd1, the request code whose melody repeats (background theme); all other codes play once.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per video frame; the note-duration timebase.
- sound_sel  in  4  request code from the event mux. 0 = none; 1 = theme; 2 = bonus; 4 = collision; 8 = win; 9 = lose. Any other value is treated as 0.
- tone_div  out  DIV_W  half-period divider for the tone generator; 0 during rests and idle.
- tone_en  out  1  tone generator enable; high only while a non-rest note plays.
- active_code  out  4  code currently playing; 0 when idle.
- busy  out  1  high in any state except IDLE.
- seq_done  out  1  one-cycle pulse when a non-looping melody finishes naturally.

Behaviour:
- Reset: synchronous, active-high, wins over all other inputs. Result: state=IDLE, all outputs 0, note address 0, duration counter 0. Reset mid-melody silences tone_en on the next cycle.
- ROM entry is 9 bits: tone[3:0], dur[3:0], last.
  - tone 0 = rest; tones 1..12 = one octave; 13..15 = rest.
  - A note lasts dur+1 frame_start pulses.
  - ROM is synchronous, 1-cycle read latency.
  - The start address per code comes from a constant table.
- Request acceptance (evaluated every cycle):
  - Start if sound_sel is a valid nonzero code AND (state==IDLE OR sound_sel > active_code numerically).
  - An equal or lower code while busy is ignored; a held request does not retrigger.
  - On start: active_code <= sound_sel, addr <= start address, go to LOAD.
  - A higher-priority preemption takes effect from any state and aborts the current note immediately.
- States:
  - IDLE: outputs silent; wait for a request.
  - LOAD: issue ROM read; go to LATCH next cycle.
  - LATCH: capture tone, dur, last. Set dur_cnt <= dur, tone_div <= lookup(tone), tone_en <= (tone in 1..12). Go to PLAY. The first audible cycle is 2 cycles after the accepting cycle.
  - PLAY: on frame_start, if dur_cnt!=0 then dur_cnt-1; else go to NEXT.
  - NEXT: tone_en <= 0 for this single cycle (articulation gap).
    - If !last: addr+1, go to LOAD.
    - If last and active_code==LOOP_CODE: addr <= start address, go to LOAD.
    - Otherwise: pulse seq_done, active_code <= 0, go to IDLE.
- sound_sel==0 while the looping theme plays: stop at the next cycle, go to IDLE, no seq_done. A non-looping melody plays to completion regardless of sound_sel dropping to 0.
- A frame_start arriving in LOAD, LATCH or NEXT is ignored; durations are counted only in PLAY.
- Address arithmetic wraps modulo 2^ROM_AW. ROM content guarantees every melody ends with last=1 before any wrap.
- Divider lookup is combinational from tone and registered in LATCH. Divider values come from a package table computed for a 50 MHz clk.

Decomposition:
- Package audio_pkg holds:
  - Sound-code constants: SND_NONE, SND_THEME, SND_BONUS, SND_COLLIDE, SND_WIN, SND_LOSE.
  - Note-entry struct note_t {tone, dur, last}.
  - State enum seq_state_t.
  - Tone-to-divider constant array.
  - Per-code start-address table.
- One sub-module, note_rom: synchronous ROM, ROM_AW address, 9-bit data, initialised from a constant array.

Test Plan:
- After reset, hold sound_sel=0 for 100 frames -> tone_en=0, busy=0, tone_div=0 throughout.
- Pulse sound_sel=4 for 1 cycle; collision melody of 3 notes, dur=1,1,3 -> tone_en rises 2 cycles later. Notes last 2, 2, 4 frames with 1-cycle gaps. seq_done pulses once, then active_code=0.
- Theme playing (code 1); raise sound_sel=4 mid-note -> within 1 cycle active_code=4 and the collision melody starts. After it ends the block is idle, and the theme does not resume until re-requested.
- Collision playing; sound_sel=2 (lower priority) -> ignored, no restart, active_code stays 4.
- Theme at its last note, sound_sel held at 1 -> loops to first note without seq_done. Drop sound_sel to 0 -> IDLE next cycle, tone_en=0.
- Assert reset during PLAY with frame_start in the same cycle -> next cycle all outputs 0, state=IDLE, and no seq_done.
